ccd_clock_generator: RTL and testbench
======================================

CCD_CLOCK_GENERATOR -- requirements
Module: ccd_clock_generator

Interface
REQ-001 SHALL have parameter N_PIXELS, default 16: serial pixel shifts per row (range 1..4095).
REQ-002 SHALL have parameter N_ROWS, default 8: parallel row transfers per frame (range 1..4095).
REQ-003 SHALL have parameter DIV, default 1: i_clk cycles per timing tick (range 1..255).
REQ-004 SHALL have parameter P_WIDTH, default 3: ticks that o_phi_p is high per row (range 1..255).
REQ-005 SHALL have parameter GAP, default 1: settle ticks between the phi_p fall and the first serial shift (range 0..255).
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port i_enable, input, 1 bit: run permission; low forces abort to IDLE.
REQ-009 SHALL have port i_start, input, 1 bit: single-cycle frame request, sampled only in IDLE.
REQ-010 SHALL have port i_continuous, input, 1 bit: when high at frame end, the next frame starts with no IDLE cycle.
REQ-011 SHALL have port o_phi_p, output, 1 bit: parallel (vertical) transfer clock.
REQ-012 SHALL have port o_phi_l1, output, 1 bit: serial phase 1.
REQ-013 SHALL have port o_phi_l2, output, 1 bit: serial phase 2.
REQ-014 SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port o_row_done, output, 1 bit: one-clock pulse at the end of each row.
REQ-016 SHALL have port o_frame_done, output, 1 bit: one-clock pulse at the end of each frame.
REQ-017 SHALL have port o_row_idx, output, 12 bits: current row, 0-based.
REQ-018 SHALL have port o_pix_idx, output, 12 bits: completed pixels in the current row.

Function
REQ-019 SHALL implement FSM states IDLE, PTRANS, SETTLE, SHIFT.
REQ-020 SHALL use idle levels phi_p=0, phi_l1=1, phi_l2=0 in IDLE, PTRANS (except phi_p) and SETTLE.
REQ-021 IDLE -> PTRANS SHALL occur when i_start=1 and i_enable=1 on a clock edge; o_phi_p SHALL be high from the next cycle.
REQ-022 PTRANS SHALL last P_WIDTH ticks with o_phi_p=1, then go to SETTLE; SETTLE lasts GAP ticks (skipped if GAP=0), then goes to SHIFT.
REQ-023 SHIFT SHALL last 2*N_PIXELS ticks alternating (l1=0,l2=1) then (l1=1,l2=0); phi_l1 and phi_l2 SHALL never both be high.
REQ-024 o_pix_idx SHALL increment on each phi_l2 fall and clear on entry to PTRANS.
REQ-025 At the end of SHIFT, o_row_done SHALL pulse one clock; if o_row_idx < N_ROWS-1, increment o_row_idx and go to PTRANS, otherwise pulse o_frame_done in the same cycle.
REQ-026 At frame end with i_continuous=1: o_row_idx SHALL clear and the FSM go to PTRANS; with i_continuous=0: go to IDLE.
REQ-027 Row length SHALL be exactly DIV*(P_WIDTH+GAP+2*N_PIXELS) clocks; frame length SHALL be N_ROWS times the row length.
REQ-028 i_enable=0 in any state SHALL force IDLE at the next edge: idle levels, indices cleared, no done pulses.
REQ-029 i_start while busy SHALL be ignored; i_start and i_enable=0 together SHALL be ignored.
REQ-030 The tick counter SHALL restart on every state entry so that the first tick of each state is a full DIV clocks.

Reset
REQ-031 When i_rst_n=0, the block SHALL enter IDLE asynchronously with o_phi_p=0, o_phi_l1=1, o_phi_l2=0, o_busy=0, both done pulses 0, and indices 0.
REQ-032 After reset release, the block SHALL not start until a fresh i_start is seen; reset mid-frame SHALL truncate with no done pulses.

Structure
REQ-033 Package ccd_timing_pkg SHALL hold the state enum, the idle-level constants and the 12-bit index width.
REQ-034 The tick prescaler SHALL be a sub-module ccd_tick_div (counter 0..DIV-1, restart input, single-cycle tick output).

Verification
REQ-035 N_PIXELS=4, N_ROWS=2, P_WIDTH=3, GAP=1, DIV=1, one i_start -> 2 phi_p pulses of 3 clocks, 8 phi_l2 pulses, o_frame_done exactly 24 clocks after the start edge, then IDLE.
REQ-036 Same parameters with DIV=2 -> phi_p pulses 6 clocks wide, frame_done at 48 clocks, l1/l2 never both high.
REQ-037 i_continuous=1 across a frame end -> o_phi_p rises on the cycle after o_frame_done, o_busy stays high, o_row_idx=0.
REQ-038 i_enable dropped mid-SHIFT at pixel 2 -> next cycle idle levels, o_busy=0, o_pix_idx=0, no o_row_done.
REQ-039 i_rst_n asserted asynchronously mid-PTRANS -> outputs at reset values immediately; i_start pulsed while busy -> no effect on timing.

Source files
------------

// File: rtl/ccd_timing_pkg.sv
// rtl/ccd_timing_pkg.sv - shared state encoding, idle phase levels and index width for the CCD clock generator
package ccd_timing_pkg;

  localparam int IDX_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PTRANS = 2'd1,
    ST_SETTLE = 2'd2,
    ST_SHIFT  = 2'd3
  } ccd_state_t;

  // Quiescent clock levels: parallel clock low, serial register parked with phase 1 high.
  localparam logic IDLE_PHI_P  = 1'b0;
  localparam logic IDLE_PHI_L1 = 1'b1;
  localparam logic IDLE_PHI_L2 = 1'b0;

  typedef struct packed {
    logic phi_p;
    logic phi_l1;
    logic phi_l2;
  } ccd_phases_t;

  localparam ccd_phases_t PHASES_IDLE = '{phi_p: IDLE_PHI_P, phi_l1: IDLE_PHI_L1, phi_l2: IDLE_PHI_L2};

  // Serial phase pair for one half of a pixel shift: half 0 drives l2, half 1 drives l1.
  function automatic ccd_phases_t shift_phases(input logic half);
    ccd_phases_t p;
    p.phi_p  = IDLE_PHI_P;
    p.phi_l1 = half;
    p.phi_l2 = ~half;
    return p;
  endfunction

endpackage

// File: rtl/ccd_tick_div.sv
// rtl/ccd_tick_div.sv - restartable prescaler producing one tick every DIV clocks
module ccd_tick_div #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // The tick lands on the last clock of each DIV-clock window.
  assign tick = (cnt == LAST);

  // Count 0..DIV-1; a restart makes the next window a full DIV clocks long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ccd_clock_generator.sv
// rtl/ccd_clock_generator.sv - CCD parallel/serial clock sequencer for row and frame readout
module ccd_clock_generator
  import ccd_timing_pkg::*;
#(
  parameter int N_PIXELS = 16,
  parameter int N_ROWS   = 8,
  parameter int DIV      = 1,
  parameter int P_WIDTH  = 3,
  parameter int GAP      = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_start,
  input  logic             i_continuous,
  output logic             o_phi_p,
  output logic             o_phi_l1,
  output logic             o_phi_l2,
  output logic             o_busy,
  output logic             o_row_done,
  output logic             o_frame_done,
  output logic [IDX_W-1:0] o_row_idx,
  output logic [IDX_W-1:0] o_pix_idx
);

  localparam logic [7:0]       P_LAST   = 8'(P_WIDTH - 1);
  localparam logic [7:0]       G_LAST   = 8'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IDX_W-1:0] PIX_LAST = IDX_W'(N_PIXELS);
  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(N_ROWS - 1);

  ccd_state_t       state;
  ccd_state_t       state_next;
  logic             tick;
  logic             restart;
  logic [7:0]       tcnt;
  logic             half;
  logic [IDX_W-1:0] row_idx;
  logic [IDX_W-1:0] pix_idx;
  logic             ptrans_end;
  logic             settle_end;
  logic             row_end;
  logic             last_row;
  ccd_phases_t      phases;

  // Every state entry (and all of IDLE) restarts the prescaler so each state begins on a full tick.
  assign restart = (state == ST_IDLE) || (state_next != state);

  ccd_tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .restart (restart),
    .tick    (tick)
  );

  // Row ends on the final tick of the second half of the last pixel.
  assign ptrans_end = (state == ST_PTRANS) && tick && (tcnt == P_LAST);
  assign settle_end = (state == ST_SETTLE) && tick && (tcnt == G_LAST);
  assign row_end    = (state == ST_SHIFT) && tick && half && (pix_idx == PIX_LAST);
  assign last_row   = (row_idx == ROW_LAST);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; losing enable overrides every other transition.
  always_comb begin
    state_next = state;
    if (!i_enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) state_next = ST_PTRANS;
        end
        ST_PTRANS: begin
          if (ptrans_end) state_next = (GAP == 0) ? ST_SHIFT : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_end) state_next = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (row_end) state_next = (!last_row || i_continuous) ? ST_PTRANS : ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Ticks spent in the current PTRANS/SETTLE state; cleared on each state entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tcnt <= '0;
    end else if (restart) begin
      tcnt <= '0;
    end else if (tick && (state == ST_PTRANS || state == ST_SETTLE)) begin
      tcnt <= tcnt + 8'd1;
    end
  end

  // Serial half-phase: starts at half 0 on SHIFT entry, flips every tick while shifting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      half <= 1'b0;
    end else if (state != ST_SHIFT || state_next != ST_SHIFT) begin
      half <= 1'b0;
    end else if (tick) begin
      half <= ~half;
    end
  end

  // Completed-pixel count: bumps as phi_l2 falls, cleared on PTRANS entry or abort.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pix_idx <= '0;
    end else if (state_next == ST_IDLE || (state_next == ST_PTRANS && state != ST_PTRANS)) begin
      pix_idx <= '0;
    end else if (state == ST_SHIFT && tick && !half) begin
      pix_idx <= pix_idx + IDX_W'(1);
    end
  end

  // Row index: advances per row, wraps at frame end, cleared whenever heading to IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_idx <= '0;
    end else if (state_next == ST_IDLE) begin
      row_idx <= '0;
    end else if (row_end) begin
      row_idx <= last_row ? '0 : row_idx + IDX_W'(1);
    end
  end

  // Output decode from the current state; done pulses are suppressed while enable is low.
  always_comb begin
    phases = PHASES_IDLE;
    case (state)
      ST_PTRANS: phases.phi_p = 1'b1;
      ST_SHIFT:  phases = shift_phases(half);
      default:   phases = PHASES_IDLE;
    endcase
    o_phi_p      = phases.phi_p;
    o_phi_l1     = phases.phi_l1;
    o_phi_l2     = phases.phi_l2;
    o_busy       = (state != ST_IDLE);
    o_row_done   = row_end && i_enable;
    o_frame_done = row_end && i_enable && last_row;
    o_row_idx    = row_idx;
    o_pix_idx    = pix_idx;
  end

endmodule

// File: tb/tb_ccd_clock_generator.sv
// tb/tb_ccd_clock_generator.sv - directed scoreboard bench for ccd_clock_generator
module tb_ccd_clock_generator;

  localparam int NP = 4;
  localparam int NR = 2;
  localparam int PW = 3;
  localparam int GP = 1;
  localparam int ROW_TICKS = PW + GP + 2 * NP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, enable, cont, start_a, start_b;

  logic phi_p_a, phi_l1_a, phi_l2_a, busy_a, row_done_a, frame_done_a;
  logic [11:0] row_idx_a, pix_idx_a;
  logic phi_p_b, phi_l1_b, phi_l2_b, busy_b, row_done_b, frame_done_b;
  logic [11:0] row_idx_b, pix_idx_b;

  ccd_clock_generator #(.N_PIXELS(NP), .N_ROWS(NR), .DIV(1), .P_WIDTH(PW), .GAP(GP)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_start(start_a), .i_continuous(cont),
    .o_phi_p(phi_p_a), .o_phi_l1(phi_l1_a), .o_phi_l2(phi_l2_a), .o_busy(busy_a),
    .o_row_done(row_done_a), .o_frame_done(frame_done_a), .o_row_idx(row_idx_a), .o_pix_idx(pix_idx_a)
  );

  ccd_clock_generator #(.N_PIXELS(NP), .N_ROWS(NR), .DIV(2), .P_WIDTH(PW), .GAP(GP)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_start(start_b), .i_continuous(1'b0),
    .o_phi_p(phi_p_b), .o_phi_l1(phi_l1_b), .o_phi_l2(phi_l2_b), .o_busy(busy_b),
    .o_row_done(row_done_b), .o_frame_done(frame_done_b), .o_row_idx(row_idx_b), .o_pix_idx(pix_idx_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t sb[$];

  int m_fd_k, m_pulses, m_wmin, m_wmax, m_l2p, m_rdn, m_ovl, m_pix_rd, m_row_fd, m_busy_end;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs, 32'(e.val));
    end
  endtask

  task automatic run_frame(input bit sel_b, input int ncyc, input int repulse);
    logic pp, l1, l2, bz, rd, fd;
    logic [11:0] ri, pi;
    bit prev_p, prev_l2;
    int run;
    prev_p = 0; prev_l2 = 0; run = 0;
    m_fd_k = -1; m_pulses = 0; m_wmin = 9999; m_wmax = 0; m_l2p = 0;
    m_rdn = 0; m_ovl = 0; m_pix_rd = -1; m_row_fd = -1; m_busy_end = -1;
    @(negedge clk);
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      pp = sel_b ? phi_p_b : phi_p_a;
      l1 = sel_b ? phi_l1_b : phi_l1_a;
      l2 = sel_b ? phi_l2_b : phi_l2_a;
      bz = sel_b ? busy_b : busy_a;
      rd = sel_b ? row_done_b : row_done_a;
      fd = sel_b ? frame_done_b : frame_done_a;
      ri = sel_b ? row_idx_b : row_idx_a;
      pi = sel_b ? pix_idx_b : pix_idx_a;
      if (pp) run++;
      if (pp && !prev_p) m_pulses++;
      if (!pp && prev_p) begin
        if (run < m_wmin) m_wmin = run;
        if (run > m_wmax) m_wmax = run;
        run = 0;
      end
      if (l2 && !prev_l2) m_l2p++;
      if (l1 && l2) m_ovl++;
      if (rd) begin
        if (m_rdn == 0) m_pix_rd = int'(pi);
        m_rdn++;
      end
      if (fd && m_fd_k < 0) begin
        m_fd_k = k;
        m_row_fd = int'(ri);
      end
      prev_p = pp;
      prev_l2 = l2;
      m_busy_end = int'(bz);
      if (k == repulse) begin
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0; start_b = 1'b0;
      end
    end
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic push_frame_expect(input int div);
    push("fd_cycle", 2 * ROW_TICKS * div - 1);
    push("phi_p_pulses", NR);
    push("phi_p_wmin", PW * div);
    push("phi_p_wmax", PW * div);
    push("l2_pulses", NR * NP);
    push("row_done_cnt", NR);
    push("l1_l2_overlap", 0);
    push("pix_at_row_done", NP);
    push("row_at_frame_done", NR - 1);
    push("busy_after_frame", 0);
  endtask

  task automatic pop_frame_results();
    pop_check(32'(m_fd_k));
    pop_check(32'(m_pulses));
    pop_check(32'(m_wmin));
    pop_check(32'(m_wmax));
    pop_check(32'(m_l2p));
    pop_check(32'(m_rdn));
    pop_check(32'(m_ovl));
    pop_check(32'(m_pix_rd));
    pop_check(32'(m_row_fd));
    pop_check(32'(m_busy_end));
  endtask

  task automatic wait_fd_a(input int budget, output bit found);
    found = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (frame_done_a) begin
        found = 1;
        break;
      end
    end
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_levels"}, {26'd0, phi_p_a, phi_l1_a, phi_l2_a, busy_a, row_done_a, frame_done_a}, 32'b010000);
    check({tag, "_row_idx"}, {20'd0, row_idx_a}, 32'd0);
    check({tag, "_pix_idx"}, {20'd0, pix_idx_a}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int rd_seen;
    rst_n = 1'b0; enable = 1'b1; cont = 1'b0; start_a = 1'b0; start_b = 1'b0;

    #12;
    check_idle_a("reset");
    check("reset_b_levels", {26'd0, phi_p_b, phi_l1_b, phi_l2_b, busy_b, row_done_b, frame_done_b}, 32'b010000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_start_after_reset", {31'd0, busy_a}, 32'd0);

    // Single frame, DIV=1, with a start pulse while busy that must be ignored.
    push_frame_expect(1);
    run_frame(1'b0, 30, 1);
    pop_frame_results();

    // Single frame, DIV=2.
    push_frame_expect(2);
    run_frame(1'b1, 55, -1);
    pop_frame_results();

    // Continuous mode across a frame end.
    cont = 1'b1;
    push("cont_fd_seen", 1);
    push("cont_phi_p_at_fd", 0);
    push("cont_busy_at_fd", 1);
    push("cont_phi_p_after", 1);
    push("cont_busy_after", 1);
    push("cont_row_idx_after", 0);
    push("cont_fd_after", 0);
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    wait_fd_a(40, found);
    pop_check(32'(found));
    pop_check(32'(phi_p_a));
    pop_check(32'(busy_a));
    @(posedge clk); #1;
    pop_check(32'(phi_p_a));
    pop_check(32'(busy_a));
    pop_check({20'd0, row_idx_a});
    pop_check(32'(frame_done_a));
    cont = 1'b0;
    push("cont_second_fd_seen", 1);
    push("cont_idle_after", 0);
    wait_fd_a(40, found);
    pop_check(32'(found));
    @(posedge clk); #1;
    pop_check(32'(busy_a));

    // Enable dropped mid-SHIFT at pixel 2.
    push("abort_reach_pix2", 1);
    push("abort_no_row_done_before", 0);
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    found = 0; rd_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (row_done_a) rd_seen++;
      if (pix_idx_a == 12'd2 && busy_a) begin
        found = 1;
        break;
      end
    end
    pop_check(32'(found));
    pop_check(32'(rd_seen));
    enable = 1'b0;
    check("abort_row_done_gated", {31'd0, row_done_a}, 32'd0);
    @(posedge clk); #1;
    check_idle_a("abort");
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_stays_idle", {31'd0, busy_a}, 32'd0);

    // Start with enable low is ignored.
    enable = 1'b0;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    check("start_while_disabled", {31'd0, busy_a}, 32'd0);
    enable = 1'b1;

    // Asynchronous reset in the middle of PTRANS.
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_phi_p", {31'd0, phi_p_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_a("async_reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_idle", {31'd0, busy_a}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
